// File: rtl/nested_loop_checker_if.sv
// Handshake bundle between the nested-loop action generator and its checker.
// The master side drives start and the sampled act values. The slave side returns the verdict.
interface nested_loop_checker_if #(
    parameter int W = 8
);
    logic         start;
    logic [W-1:0] act1_in;
    logic [W-1:0] act2_in;
    logic         busy;
    logic         done;
    logic         pass;
    logic [7:0]   err_cnt;
    logic [15:0]  first_err_idx;
    logic [W-1:0] exp_act1;

    modport master (
        output start, act1_in, act2_in,
        input  busy, done, pass, err_cnt, first_err_idx, exp_act1
    );

    modport slave (
        input  start, act1_in, act2_in,
        output busy, done, pass, err_cnt, first_err_idx, exp_act1
    );
endinterface

// File: rtl/nested_loop_checker.sv
// Receive-side checker for the nested-loop action generator: compares act1/act2 against the
// two-level loop sequence. Optional macro CHK_STRICT_CLEAR_EN also checks the CLEAR-cycle sample.
module nested_loop_checker #(
    parameter int OUTER_N = 10,
    parameter int INNER_N = 10,
    parameter int W       = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    nested_loop_checker_if.slave   bus
);
    localparam logic [1:0]  S_IDLE  = 2'd0;
    localparam logic [1:0]  S_RUN   = 2'd1;
    localparam logic [1:0]  S_CLEAR = 2'd2;
    localparam logic [1:0]  S_DONE  = 2'd3;

    localparam logic [15:0] LAST_K = 16'(OUTER_N * INNER_N - 1);
    localparam logic [15:0] N_IDX  = 16'(OUTER_N * INNER_N);
    localparam logic [15:0] LAST_J = 16'(INNER_N - 1);

    logic [1:0]   state_q, state_d;
    logic [15:0]  k_q, k_d;
    logic [15:0]  j_q, j_d;
    logic [W-1:0] exp_act1_q, exp_act1_d;
    logic [7:0]   err_cnt_q, err_cnt_d;
    logic [15:0]  first_err_idx_q, first_err_idx_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         pass_q, pass_d;
    logic         mismatch_s;
    logic [W-1:0] exp_now_s;

    // Next-state, expected-value and error-accounting logic.
    always_comb begin
        state_d         = state_q;
        k_d             = k_q;
        j_d             = j_q;
        exp_act1_d      = exp_act1_q;
        err_cnt_d       = err_cnt_q;
        first_err_idx_d = first_err_idx_q;
        busy_d          = busy_q;
        done_d          = 1'b0;
        pass_d          = pass_q;
        mismatch_s      = 1'b0;
        // Outer value steps whenever the inner counter is about to restart.
        exp_now_s       = (j_q == 16'd0) ? exp_act1_q + W'(1) : exp_act1_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d         = S_RUN;
                    k_d             = 16'd0;
                    j_d             = 16'd0;
                    exp_act1_d      = '0;
                    err_cnt_d       = 8'd0;
                    first_err_idx_d = 16'hFFFF;
                    busy_d          = 1'b1;
                    pass_d          = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            S_RUN: begin
                // act2 is the previous sample's act1, which is exactly the pre-update exp_act1_q.
                mismatch_s = (bus.act1_in != exp_now_s) || (bus.act2_in != exp_act1_q);
                exp_act1_d = exp_now_s;
                j_d        = (j_q == LAST_J) ? 16'd0 : j_q + 16'd1;
                if (k_q == LAST_K) begin
                    state_d = S_CLEAR;
                end else begin
                    k_d = k_q + 16'd1;
                end
            end
            S_CLEAR: begin
`ifdef CHK_STRICT_CLEAR_EN
                mismatch_s = (bus.act1_in != '0) || (bus.act2_in != '0);
`else
                mismatch_s = 1'b0;
`endif
                state_d = S_DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                pass_d  = (err_cnt_q == 8'd0) && !mismatch_s;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (mismatch_s) begin
            err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
            if (first_err_idx_q == 16'hFFFF) begin
                first_err_idx_d = (state_q == S_CLEAR) ? N_IDX : k_q;
            end else begin
                first_err_idx_d = first_err_idx_q;
            end
        end else begin
            err_cnt_d = err_cnt_d;
        end
    end

    // State and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            k_q             <= 16'd0;
            j_q             <= 16'd0;
            exp_act1_q      <= '0;
            err_cnt_q       <= 8'd0;
            first_err_idx_q <= 16'hFFFF;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            pass_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            k_q             <= k_d;
            j_q             <= j_d;
            exp_act1_q      <= exp_act1_d;
            err_cnt_q       <= err_cnt_d;
            first_err_idx_q <= first_err_idx_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            pass_q          <= pass_d;
        end
    end

    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.pass          = pass_q;
    assign bus.err_cnt       = err_cnt_q;
    assign bus.first_err_idx = first_err_idx_q;
    assign bus.exp_act1      = exp_act1_q;
endmodule

// File: tb/tb_nested_loop_checker.sv
// Directed-plus-random bench for nested_loop_checker; a 10x10 and a 30x10 instance share the clock.
// Expected results come from an arithmetic model of the loop sequence (k/INNER_N + 1).
module tb_nested_loop_checker;
    logic clk;
    logic rst_n;
    int   checks;
    int   passed;
    int   a1 [0:400];
    int   a2 [0:400];
    int   m_err;
    int   m_idx;
    int   m_pass;

    nested_loop_checker_if #(.W(8)) bus0 ();
    nested_loop_checker_if #(.W(8)) bus1 ();

    nested_loop_checker #(.OUTER_N(10), .INNER_N(10), .W(8)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.slave)
    );

    nested_loop_checker #(.OUTER_N(30), .INNER_N(10), .W(8)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks = checks + 1;
        assert (o === e) passed = passed + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    endtask

    task automatic drv(input int which, input logic st, input int x1, input int x2);
        if (which == 0) begin
            bus0.start = st; bus0.act1_in = 8'(x1); bus0.act2_in = 8'(x2);
        end else begin
            bus1.start = st; bus1.act1_in = 8'(x1); bus1.act2_in = 8'(x2);
        end
    endtask

    task automatic obs(input int which, output logic b, output logic d, output logic p,
                       output logic [7:0] e, output logic [15:0] f, output logic [7:0] x);
        if (which == 0) begin
            b = bus0.busy; d = bus0.done; p = bus0.pass;
            e = bus0.err_cnt; f = bus0.first_err_idx; x = bus0.exp_act1;
        end else begin
            b = bus1.busy; d = bus1.done; p = bus1.pass;
            e = bus1.err_cnt; f = bus1.first_err_idx; x = bus1.exp_act1;
        end
    endtask

    function automatic int exp1(input int k, input int inner);
        return (k / inner + 1) % 256;
    endfunction

    task automatic fill(input int n, input int inner);
        for (int k = 0; k < n; k++) begin
            a1[k] = exp1(k, inner);
            a2[k] = (k == 0) ? 0 : exp1(k - 1, inner);
        end
        a1[n] = 0;
        a2[n] = 0;
    endtask

    task automatic model(input int n, input int inner);
        int cnt;
        int idx;
        bit strict;
`ifdef CHK_STRICT_CLEAR_EN
        strict = 1'b1;
`else
        strict = 1'b0;
`endif
        cnt = 0;
        idx = -1;
        for (int k = 0; k < n; k++) begin
            if (a1[k] != exp1(k, inner) || a2[k] != ((k == 0) ? 0 : exp1(k - 1, inner))) begin
                if (idx < 0) idx = k;
                cnt++;
            end
        end
        if (strict && (a1[n] != 0 || a2[n] != 0)) begin
            if (idx < 0) idx = n;
            cnt++;
        end
        m_err  = (cnt > 255) ? 255 : cnt;
        m_idx  = (idx < 0) ? 32'hFFFF : idx;
        m_pass = (cnt == 0) ? 1 : 0;
    endtask

    task automatic chk_reset(input int which, input string name);
        logic b, d, p;
        logic [7:0] e, x;
        logic [15:0] f;
        obs(which, b, d, p, e, f, x);
        chk({name, " rst_busy"}, 32'(b), 32'd0);
        chk({name, " rst_done"}, 32'(d), 32'd0);
        chk({name, " rst_pass"}, 32'(p), 32'd0);
        chk({name, " rst_err"}, 32'(e), 32'd0);
        chk({name, " rst_idx"}, 32'(f), 32'hFFFF);
        chk({name, " rst_exp"}, 32'(x), 32'd0);
    endtask

    // One start pulse, n samples plus the CLEAR sample; dupk re-pulses start, rstk aborts with reset.
    task automatic run(input int which, input int n, input int inner,
                       input int dupk, input int rstk, input string name);
        logic b, d, p;
        logic [7:0] e, x;
        logic [15:0] f;
        int bad;
        bad = 0;
        model(n, inner);
        @(negedge clk);
        drv(which, 1'b1, 0, 0);
        for (int k = 0; k <= n; k++) begin
            @(negedge clk);
            obs(which, b, d, p, e, f, x);
            if (b !== 1'b1 || d !== 1'b0) bad++;
            drv(which, k == dupk, a1[k], a2[k]);
            if (k == rstk) begin
                rst_n = 1'b0;
                #1;
                chk_reset(which, {name, " abort"});
                repeat (2) @(negedge clk);
                obs(which, b, d, p, e, f, x);
                chk({name, " abort_no_done"}, 32'(d), 32'd0);
                rst_n = 1'b1;
                drv(which, 1'b0, 0, 0);
                return;
            end
        end
        chk({name, " busy_window"}, 32'(bad), 32'd0);
        @(negedge clk);
        obs(which, b, d, p, e, f, x);
        drv(which, 1'b0, 0, 0);
        chk({name, " done"}, 32'(d), 32'd1);
        chk({name, " busy_off"}, 32'(b), 32'd0);
        chk({name, " pass"}, 32'(p), 32'(m_pass));
        chk({name, " err_cnt"}, 32'(e), 32'(m_err));
        chk({name, " first_idx"}, 32'(f), 32'(m_idx));
        chk({name, " exp_act1"}, 32'(x), 32'(exp1(n - 1, inner)));
        @(negedge clk);
        obs(which, b, d, p, e, f, x);
        chk({name, " done_pulse"}, 32'(d), 32'd0);
        chk({name, " err_held"}, 32'(e), 32'(m_err));
        chk({name, " pass_held"}, 32'(p), 32'(m_pass));
    endtask

    initial begin
        checks = 0;
        passed = 0;
        rst_n  = 1'b0;
        drv(0, 1'b0, 0, 0);
        drv(1, 1'b0, 0, 0);
        repeat (2) @(negedge clk);
        chk_reset(0, "reset0");
        chk_reset(1, "reset1");
        rst_n = 1'b1;
        @(negedge clk);

        fill(100, 10);
        run(0, 100, 10, -1, -1, "correct");

        fill(100, 10);
        a2[25] = 7;
        run(0, 100, 10, -1, -1, "single");

        for (int r = 0; r < 4; r++) begin
            int nerr;
            int kk;
            fill(100, 10);
            nerr = int'($urandom_range(1, 6));
            for (int i = 0; i < nerr; i++) begin
                kk = int'($urandom_range(0, 99));
                if ($urandom_range(0, 1) == 0) a1[kk] = int'($urandom_range(0, 255));
                else a2[kk] = int'($urandom_range(0, 255));
            end
            if ($urandom_range(0, 3) == 0) a1[100] = int'($urandom_range(1, 255));
            run(0, 100, 10, -1, -1, "random");
        end

        fill(100, 10);
        for (int k = 0; k < 100; k++) a1[k] = 0;
        run(0, 100, 10, -1, -1, "stuck");

        fill(100, 10);
        run(0, 100, 10, 40, -1, "dup_start");

        fill(100, 10);
        run(0, 100, 10, -1, 50, "mid_reset");
        fill(100, 10);
        run(0, 100, 10, -1, -1, "after_reset");

        fill(100, 10);
        a1[100] = 10;
        run(0, 100, 10, -1, -1, "clear_sample");

        fill(300, 10);
        for (int k = 0; k < 300; k++) a1[k] = 0;
        run(1, 300, 10, -1, -1, "saturate");

        fill(300, 10);
        for (int i = 0; i < 3; i++) a2[int'($urandom_range(0, 299))] = int'($urandom_range(0, 255));
        run(1, 300, 10, -1, -1, "random30");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
